// File: rtl/spi_adc_frame_receiver.sv
// spi_adc_frame_receiver
// SPI master receive engine for serial-output ADC Pmods (PmodALS, ADC081S,
// ADCS7476 class parts). It drives CS and SCK, shifts in FRAME_BITS bits
// MSB-first and presents the field shift[FIELD_LSB +: FIELD_WIDTH] on a
// valid/ready interface. Frames are either one-shot (start) or free-running
// (mode_continuous), separated by at least GAP_CYCLES clocks of CS high.
//
// Optional build macro SPI_ADC_OVERRUN_STATUS_EN adds the overrun and
// overrun_count ports. They flag frames that were overwritten before the
// consumer accepted them. Without the macro such overwrites are silent.
module spi_adc_frame_receiver #(
  parameter int CLK_DIV     = 2,
  parameter int FRAME_BITS  = 16,
  parameter int FIELD_LSB   = 0,
  parameter int FIELD_WIDTH = 16,
  parameter int GAP_CYCLES  = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode_continuous,
  input  logic                   start,
  output logic                   cs,
  output logic                   sck,
  input  logic                   sdo,
  output logic                   busy,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [FIELD_WIDTH-1:0] frame_data
`ifdef SPI_ADC_OVERRUN_STATUS_EN
  ,
  output logic                   overrun,
  output logic [7:0]             overrun_count
`endif
);

  // One shared counter times the SCK half-periods, the SETUP phase and the gap.
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic                    frame_done;

  // A frame completes at the end of the high half of the last bit period.
  // That is the same edge on which the FSM enters GAP.
  assign frame_done = (state == SHIFT) && sck && (cnt == DIV_LAST) &&
                      (bit_cnt == BIT_LAST);

  // Frame sequencer: the CS/SCK waveform, the bit shifting and the busy flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cs        <= 1'b1;
      sck       <= 1'b1;
      busy      <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (mode_continuous || start) begin
            state <= SETUP;
            cs    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            sck   <= 1'b0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!sck) begin
              // Rising SCK edge: the device has held sdo stable for the whole low half.
              sck       <= 1'b1;
              shift_reg <= {shift_reg[FRAME_BITS-2:0], sdo};
            end else if (bit_cnt == BIT_LAST) begin
              state   <= GAP;
              cs      <= 1'b1;
              bit_cnt <= '0;
            end else begin
              sck     <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cs    <= 1'b1;
          sck   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register. The newest frame always wins, and acceptance drops valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else if (frame_done) begin
      frame_valid <= 1'b1;
      frame_data  <= shift_reg[FIELD_LSB +: FIELD_WIDTH];
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

`ifdef SPI_ADC_OVERRUN_STATUS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic overwrite;
  // A frame is lost only if the previous one is still pending and is not being accepted now.
  assign overwrite = frame_done && frame_valid && !frame_ready;

  // Sticky overrun flag with a saturating count of lost frames.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun       <= 1'b0;
      overrun_count <= 8'd0;
    end else if (overwrite) begin
      overrun       <= 1'b1;
      overrun_count <= sat_inc8(overrun_count);
    end
  end
`endif

endmodule

// File: tb/tb_spi_adc_frame_receiver.sv
// Self-checking bench for spi_adc_frame_receiver. Four instances cover the
// default configuration, a PmodALS-style field extraction, continuous mode
// with a short gap, and the smallest legal frame (CLK_DIV=1, FRAME_BITS=2).
module tb_spi_adc_frame_receiver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Reference rules, computed from the frame definition.
  function automatic logic [31:0] field_of(input logic [31:0] word, input int lsb,
                                           input int width);
    longint unsigned m;
    m = (64'd1 << width) - 1;
    return 32'((longint'(word) >> lsb) & m);
  endfunction

  function automatic int cs_low_clocks(input int cd, input int fb);
    return cd + 2 * cd * fb;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int CD = (g == 1) ? 4 : ((g == 3) ? 1 : 2);
    localparam int FB = (g == 3) ? 2 : 16;
    localparam int FL = (g == 1) ? 4 : 0;
    localparam int FW = (g == 1) ? 8 : ((g == 3) ? 2 : 16);
    localparam int GC = (g == 2) ? 8 : ((g == 3) ? 3 : 1024);

    logic rst = 1'b1;
    logic st  = 1'b0;
    logic mc  = 1'b0;
    logic fr  = 1'b1;
    logic cs, sck, busy, fv, sdo;
    logic [FW-1:0] fd;
    logic [15:0]   fd16;
    logic [31:0]   tx_tab [8];
    logic [31:0]   cur = '0;
    int idx = 0, started = 0, ends = 0, low_len = 0, last_low = 0;
    int rises = 0, last_rises = 0, cyc = 0, last_rise_cyc = 0, sck_per = 0;
    int last_fall_cyc = 0, fall_per = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b1;
`ifdef SPI_ADC_OVERRUN_STATUS_EN
    logic       ovr;
    logic [7:0] ovr_cnt;
`endif

    assign fd16 = 16'(fd);
    assign sdo  = (idx < FB) ? cur[FB-1-idx] : 1'b0;

    spi_adc_frame_receiver #(
      .CLK_DIV(CD), .FRAME_BITS(FB), .FIELD_LSB(FL), .FIELD_WIDTH(FW),
      .GAP_CYCLES(GC)
    ) u_dut (
      .clock(clock), .reset(rst), .mode_continuous(mc), .start(st),
      .cs(cs), .sck(sck), .sdo(sdo), .busy(busy), .frame_valid(fv),
      .frame_ready(fr), .frame_data(fd)
`ifdef SPI_ADC_OVERRUN_STATUS_EN
      , .overrun(ovr), .overrun_count(ovr_cnt)
`endif
    );

    // Device model and pin monitor: present the next bit after each rising SCK,
    // and measure the CS-low time, the number of SCK edges and the periods.
    always @(posedge clock) begin
      #1;
      cyc++;
      if (prev_cs && !cs) begin
        idx = 0; rises = 0; low_len = 0;
        cur = tx_tab[started % 8];
        started++;
        fall_per = cyc - last_fall_cyc;
        last_fall_cyc = cyc;
      end
      if (!cs) low_len++;
      if (!prev_sck && sck) begin
        if (rises > 0) sck_per = cyc - last_rise_cyc;
        last_rise_cyc = cyc;
        idx++;
        rises++;
      end
      if (!prev_cs && cs) begin
        last_low = low_len;
        last_rises = rises;
        ends++;
      end
      prev_cs  = cs;
      prev_sck = sck;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] words [3];
    int n, s0, e0;

    // Reset state
    wait_clk(3);
    check_eq("rst_cs",   32'(gen_dut[0].cs), 1);
    check_eq("rst_sck",  32'(gen_dut[0].sck), 1);
    check_eq("rst_busy", 32'(gen_dut[0].busy), 0);
    check_eq("rst_fv",   32'(gen_dut[0].fv), 0);
    check_eq("rst_fd",   32'(gen_dut[0].fd16), 0);
    gen_dut[0].rst = 1'b0; gen_dut[1].rst = 1'b0;
    gen_dut[2].rst = 1'b0; gen_dut[3].rst = 1'b0;
    wait_clk(2);

    // Default configuration: one-shot 0xA5C3, then random words
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 32'hA5C3 : ($urandom & 32'hFFFF);
      gen_dut[0].tx_tab[gen_dut[0].started % 8] = w;
      gen_dut[0].fr = 1'b1;
      gen_dut[0].st = 1'b1;
      wait_clk(1);
      gen_dut[0].st = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (gen_dut[0].fv) break;
        wait_clk(1);
      end
      check_eq("def_valid", 32'(gen_dut[0].fv), 1);
      check_eq("def_data",  32'(gen_dut[0].fd16), field_of(w, 0, 16));
      check_eq("def_cs_low", 32'(gen_dut[0].last_low), 32'(cs_low_clocks(2, 16)));
      check_eq("def_rises", 32'(gen_dut[0].last_rises), 16);
      check_eq("def_busy_gap", 32'(gen_dut[0].busy), 1);
      wait_clk(1);
      check_eq("def_valid_1clk", 32'(gen_dut[0].fv), 0);
      n = 1;
      while (gen_dut[0].busy && n < 2000) begin
        wait_clk(1);
        n++;
      end
      check_eq("def_gap_len", 32'(n), 1024);
      wait_clk(2);
    end

    // start pulses while busy are ignored, and start in IDLE begins a new frame
    gen_dut[0].fr = 1'b0;
    s0 = gen_dut[0].started;
    gen_dut[0].tx_tab[s0 % 8] = 32'h5A5A;
    gen_dut[0].st = 1'b1; wait_clk(1); gen_dut[0].st = 1'b0;
    wait_clk(9);
    gen_dut[0].st = 1'b1; wait_clk(1); gen_dut[0].st = 1'b0;
    wait_clk(19);
    gen_dut[0].st = 1'b1; wait_clk(1); gen_dut[0].st = 1'b0;
    wait_clk(19);
    gen_dut[0].st = 1'b1; wait_clk(1); gen_dut[0].st = 1'b0;
    n = 0;
    while (gen_dut[0].busy && n < 3000) begin
      wait_clk(1);
      n++;
    end
    wait_clk(20);
    check_eq("ign_frames", 32'(gen_dut[0].started - s0), 1);
    check_eq("ign_idle",   32'(gen_dut[0].busy), 0);
    check_eq("ign_data",   32'(gen_dut[0].fd16), 32'h5A5A);
    gen_dut[0].tx_tab[gen_dut[0].started % 8] = 32'hFFFF;
    gen_dut[0].st = 1'b1; wait_clk(1); gen_dut[0].st = 1'b0;
    wait_clk(2);
    check_eq("idle_start_frames", 32'(gen_dut[0].started - s0), 2);
    check_eq("idle_start_busy",   32'(gen_dut[0].busy), 1);

    // Reset in the middle of the frame, then a clean 0x1234 frame
    for (int i = 0; i < 200; i++) begin
      if (gen_dut[0].rises >= 7) break;
      wait_clk(1);
    end
    check_eq("abort_at_bit7", 32'(gen_dut[0].rises), 7);
    gen_dut[0].rst = 1'b1;
    wait_clk(1);
    check_eq("abort_cs",   32'(gen_dut[0].cs), 1);
    check_eq("abort_sck",  32'(gen_dut[0].sck), 1);
    check_eq("abort_fv",   32'(gen_dut[0].fv), 0);
    check_eq("abort_fd",   32'(gen_dut[0].fd16), 0);
    check_eq("abort_busy", 32'(gen_dut[0].busy), 0);
    gen_dut[0].rst = 1'b0;
    gen_dut[0].fr  = 1'b1;
    wait_clk(2);
    gen_dut[0].tx_tab[gen_dut[0].started % 8] = 32'h1234;
    gen_dut[0].st = 1'b1; wait_clk(1); gen_dut[0].st = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (gen_dut[0].fv) break;
      wait_clk(1);
    end
    check_eq("post_rst_valid", 32'(gen_dut[0].fv), 1);
    check_eq("post_rst_data",  32'(gen_dut[0].fd16), 32'h1234);
    check_eq("post_rst_cs_low", 32'(gen_dut[0].last_low), 32'(cs_low_clocks(2, 16)));

    // PmodALS-style field: bits [11:4] of the frame, SCK period 8 clocks
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 32'h0B30 : ($urandom & 32'hFFFF);
      gen_dut[1].tx_tab[gen_dut[1].started % 8] = w;
      gen_dut[1].st = 1'b1; wait_clk(1); gen_dut[1].st = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (gen_dut[1].fv) break;
        wait_clk(1);
      end
      check_eq("als_valid",  32'(gen_dut[1].fv), 1);
      check_eq("als_data",   32'(gen_dut[1].fd16), field_of(w, 4, 8));
      check_eq("als_cs_low", 32'(gen_dut[1].last_low), 32'(cs_low_clocks(4, 16)));
      check_eq("als_sck_period", 32'(gen_dut[1].sck_per), 8);
      n = 0;
      while (gen_dut[1].busy && n < 2000) begin
        wait_clk(1);
        n++;
      end
      wait_clk(2);
    end

    // Continuous mode, consumer stalled: the newest of three frames wins
    gen_dut[2].fr = 1'b0;
    s0 = gen_dut[2].started;
    e0 = gen_dut[2].ends;
    for (int k = 0; k < 3; k++) begin
      words[k] = $urandom & 32'hFFFF;
      gen_dut[2].tx_tab[(s0 + k) % 8] = words[k];
    end
    gen_dut[2].mc = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (gen_dut[2].started - s0 >= 3) break;
      wait_clk(1);
    end
    gen_dut[2].mc = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (gen_dut[2].ends - e0 >= 3) break;
      wait_clk(1);
    end
    wait_clk(20);
    check_eq("cont_frames", 32'(gen_dut[2].started - s0), 3);
    check_eq("cont_valid",  32'(gen_dut[2].fv), 1);
    check_eq("cont_data",   32'(gen_dut[2].fd16), field_of(words[2], 0, 16));
    check_eq("cont_period", 32'(gen_dut[2].fall_per),
             32'(cs_low_clocks(2, 16) + 8 + 1));
`ifdef SPI_ADC_OVERRUN_STATUS_EN
    check_eq("cont_overrun",     32'(gen_dut[2].ovr), 1);
    check_eq("cont_overrun_cnt", 32'(gen_dut[2].ovr_cnt), 2);
`endif
    gen_dut[2].fr = 1'b1;
    wait_clk(1);
    check_eq("cont_accept", 32'(gen_dut[2].fv), 0);

    // Smallest frame: CLK_DIV=1, FRAME_BITS=2, every 2-bit pattern
    for (int v = 0; v < 4; v++) begin
      gen_dut[3].tx_tab[gen_dut[3].started % 8] = 32'(v);
      gen_dut[3].st = 1'b1; wait_clk(1); gen_dut[3].st = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (gen_dut[3].fv) break;
        wait_clk(1);
      end
      check_eq("min_valid",  32'(gen_dut[3].fv), 1);
      check_eq("min_data",   32'(gen_dut[3].fd16), field_of(32'(v), 0, 2));
      check_eq("min_cs_low", 32'(gen_dut[3].last_low), 32'(cs_low_clocks(1, 2)));
      check_eq("min_rises",  32'(gen_dut[3].last_rises), 2);
      n = 0;
      while (gen_dut[3].busy && n < 50) begin
        wait_clk(1);
        n++;
      end
      wait_clk(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
